// File: rtl/mc_act_arb_ap.sv
`default_nettype none
// ============================================================================
// Module   : mc_act_arb_ap
// Brief    : 4-way round-robin activate arbiter with tRRD spacing and optional
//            tFAW four-activate window (enabled by MC_ACT_ARB_FAW_EN).
// Revision : 1.0 - initial release
// ============================================================================
module mc_act_arb_ap #(
    parameter int TRRD  = 4,
    parameter int TFAW  = 16,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       inhibit,
    output logic [3:0] sel,
    output logic       actVld,
    output logic [1:0] rrPtr,
    output logic       fawBlk
);

    localparam logic [CNT_W-1:0] c_rrd_load = CNT_W'(TRRD - 1);

    logic [CNT_W-1:0] r_rrd_cnt;
    logic             w_rrd_ok;
    logic             w_faw_ok;
    logic             w_grant;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_win;

    generate
        if (TRRD < 1 || TRRD > 15 || TFAW < 4 || TFAW > 64 || (2 ** CNT_W) <= TRRD) begin : g_bad_param
            $error("mc_act_arb_ap: illegal TRRD/TFAW/CNT_W combination");
        end
    endgenerate

    assign w_rrd_ok = (r_rrd_cnt == '0);

    // Rotate so bit 0 is the current highest-priority slot, then pick the first set bit.
    always_comb begin
        w_rot = req;
        case (rrPtr)
            2'd0:    w_rot = req;
            2'd1:    w_rot = {req[0], req[3:1]};
            2'd2:    w_rot = {req[1:0], req[3:2]};
            default: w_rot = {req[2:0], req[3]};
        endcase
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_win   = rrPtr + w_off;
    assign w_grant = (req != 4'b0000) && !inhibit && w_rrd_ok && w_faw_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= 4'b0000;
            actVld    <= 1'b0;
            rrPtr     <= 2'd0;
            r_rrd_cnt <= '0;
        end else begin
            actVld <= w_grant;
            if (w_grant) begin
                sel       <= 4'b0001 << w_win;
                rrPtr     <= w_win + 2'd1;
                r_rrd_cnt <= c_rrd_load;
            end else begin
                sel <= 4'b0000;
                if (r_rrd_cnt != '0) begin
                    r_rrd_cnt <= r_rrd_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef MC_ACT_ARB_FAW_EN
    localparam int c_hist_d = TFAW - 1;

    // r_hist[0] mirrors actVld, so the window spans the current cycle and TFAW-2 before it.
    logic [c_hist_d-1:0] r_hist;
    logic [2:0]          r_faw_cnt;

    assign w_faw_ok = (r_faw_cnt < 3'd4);
    assign fawBlk   = (req != 4'b0000) && !inhibit && w_rrd_ok && !w_faw_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_faw_cnt <= 3'd0;
        end else begin
            r_hist <= {r_hist[c_hist_d-2:0], w_grant};
            case ({w_grant, r_hist[c_hist_d-1]})
                2'b10: begin
                    if (r_faw_cnt != 3'd7) r_faw_cnt <= r_faw_cnt + 3'd1;
                end
                2'b01: begin
                    if (r_faw_cnt != 3'd0) r_faw_cnt <= r_faw_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end
`else
    assign w_faw_ok = 1'b1;
    assign fawBlk   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_act_arb_ap.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_act_arb_ap
// Brief    : Self-checking bench for mc_act_arb_ap (TRRD=4/TFAW=16 and
//            TRRD=1/TFAW=8 instances) against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_act_arb_ap;

`ifdef MC_ACT_ARB_FAW_EN
    localparam bit c_faw_on = 1'b1;
`else
    localparam bit c_faw_on = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       inhibit;
    logic [3:0] sel_a [2];
    logic       vld_a [2];
    logic [1:0] ptr_a [2];
    logic       fb_a  [2];

    int n_assert = 0;
    int n_fail   = 0;
    int mcyc     = 0;

    int c_trrd [2] = '{4, 1};
    int c_tfaw [2] = '{16, 8};

    // Reference model: cycle numbers of recent grants rather than counters.
    int         last_g [2];
    int         gh     [2][4];
    logic [3:0] e_sel  [2];
    logic       e_vld  [2];
    int         e_ptr  [2];
    // Observed-pulse trackers for the invariants.
    int         d_last [2];
    int         d_hist [2][4];
    int         waitc  [2][4];
    logic [3:0] prev_req;

    mc_act_arb_ap #(.TRRD(4), .TFAW(16), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .inhibit(inhibit),
        .sel(sel_a[0]), .actVld(vld_a[0]), .rrPtr(ptr_a[0]), .fawBlk(fb_a[0])
    );

    mc_act_arb_ap #(.TRRD(1), .TFAW(8), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .inhibit(inhibit),
        .sel(sel_a[1]), .actVld(vld_a[1]), .rrPtr(ptr_a[1]), .fawBlk(fb_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_g[k] = -1000;
            d_last[k] = -1000;
            e_sel[k]  = 4'b0000;
            e_vld[k]  = 1'b0;
            e_ptr[k]  = 0;
            for (int i = 0; i < 4; i++) begin
                gh[k][i]     = -1000;
                d_hist[k][i] = -1000;
                waitc[k][i]  = 0;
            end
        end
        prev_req = 4'b0000;
    endtask

    // Called mid-cycle: compare outputs, check invariants, then make this cycle's decision.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            int  cnt;
            int  dcnt;
            int  w;
            bit  rrd_ok;
            bit  exp_fb;
            rrd_ok = (mcyc - last_g[k]) >= (c_trrd[k] - 1);
            cnt = 0;
            for (int i = 0; i < 4; i++)
                if (gh[k][i] >= mcyc - c_tfaw[k] + 2) cnt++;
            exp_fb = c_faw_on && (req != 4'b0000) && !inhibit && rrd_ok && (cnt >= 4);

            chk("sel",    k, 32'(sel_a[k]), 32'(e_sel[k]));
            chk("actVld", k, 32'(vld_a[k]), 32'(e_vld[k]));
            chk("rrPtr",  k, 32'(ptr_a[k]), 32'(e_ptr[k]));
            chk("fawBlk", k, 32'(fb_a[k]),  32'(exp_fb));

            for (int j = 0; j < 4; j++)
                if (!prev_req[j]) waitc[k][j] = 0;
            if (vld_a[k] === 1'b1) begin
                chk("onehot",  k, 32'($countones(sel_a[k])), 32'd1);
                chk("spacing", k, 32'((mcyc - d_last[k]) >= c_trrd[k]), 32'd1);
                if (c_faw_on) begin
                    dcnt = 0;
                    for (int i = 0; i < 4; i++)
                        if (d_hist[k][i] >= mcyc - c_tfaw[k] + 1) dcnt++;
                    chk("faw_window", k, 32'(dcnt <= 3), 32'd1);
                end
                for (int j = 0; j < 4; j++) begin
                    if (sel_a[k][j]) begin
                        waitc[k][j] = 0;
                    end else if (prev_req[j]) begin
                        waitc[k][j]++;
                        chk("starve", k, 32'(waitc[k][j] <= 3), 32'd1);
                    end
                end
                for (int i = 3; i > 0; i--) d_hist[k][i] = d_hist[k][i-1];
                d_hist[k][0] = mcyc;
                d_last[k]    = mcyc;
            end

            w = -1;
            if ((req != 4'b0000) && !inhibit && rrd_ok && (!c_faw_on || cnt < 4)) begin
                for (int j = 0; j < 4; j++)
                    if (w < 0 && req[(e_ptr[k] + j) % 4]) w = (e_ptr[k] + j) % 4;
            end
            if (w >= 0) begin
                e_sel[k]  = 4'b0001 << w;
                e_vld[k]  = 1'b1;
                e_ptr[k]  = (w + 1) % 4;
                last_g[k] = mcyc + 1;
                for (int i = 3; i > 0; i--) gh[k][i] = gh[k][i-1];
                gh[k][0] = mcyc + 1;
            end else begin
                e_sel[k] = 4'b0000;
                e_vld[k] = 1'b0;
            end
        end
        prev_req = req;
        mcyc++;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic cycle(input logic [3:0] r, input logic inh);
        req     = r;
        inhibit = inh;
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        logic [3:0] r;
        logic       inh;

        rst     = 1'b1;
        req     = 4'b0000;
        inhibit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sel",    0, 32'(sel_a[0]), 32'h0);
        chk("rst_actVld", 0, 32'(vld_a[0]), 32'h0);
        chk("rst_rrPtr",  0, 32'(ptr_a[0]), 32'h0);
        chk("rst_fawBlk", 0, 32'(fb_a[0]),  32'h0);

        // All four requesting: rotation through every slot, window limit on the fast instance.
        cycle(4'b1111, 1'b0);
        chk("first_sel", 0, 32'(sel_a[0]), 32'h1);
        repeat (40) cycle(4'b1111, 1'b0);

        // Point at slot 2, then present slots 0 and 1: the scan must wrap to slot 0.
        repeat (6) cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b0);
        chk("wrap_pre_ptr", 0, 32'(ptr_a[0]), 32'd2);
        repeat (5) cycle(4'b0000, 1'b0);
        cycle(4'b0011, 1'b0);
        chk("wrap_sel", 0, 32'(sel_a[0]), 32'h1);
        chk("wrap_ptr", 0, 32'(ptr_a[0]), 32'd1);

        // Requester that never drops on the TRRD=1 instance.
        repeat (4) cycle(4'b0000, 1'b0);
        repeat (12) begin
            cycle(4'b0100, 1'b0);
            if (!c_faw_on) begin
                chk("b2b_vld", 1, 32'(vld_a[1]), 32'h1);
                chk("b2b_sel", 1, 32'(sel_a[1]), 32'h4);
                chk("b2b_fb",  1, 32'(fb_a[1]),  32'h0);
            end
        end

        // Inhibit held for 10 cycles over a pending request.
        repeat (6) cycle(4'b0000, 1'b0);
        repeat (10) begin
            cycle(4'b1000, 1'b1);
            chk("inh_vld", 0, 32'(vld_a[0]), 32'h0);
        end
        cycle(4'b1000, 1'b0);
        chk("inh_release_vld", 0, 32'(vld_a[0]), 32'h1);
        chk("inh_release_sel", 0, 32'(sel_a[0]), 32'h8);

        // Asynchronous reset while a grant is on the outputs.
        repeat (6) cycle(4'b0000, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(4'b1111, 1'b0);
            if (e_vld[0]) found = 1'b1;
        end
        chk("rst_setup", 0, 32'(found), 32'h1);
        #1;
        chk("pre_rst_vld", 0, 32'(vld_a[0]), 32'h1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_sel",    k, 32'(sel_a[k]), 32'h0);
            chk("async_actVld", k, 32'(vld_a[k]), 32'h0);
            chk("async_rrPtr",  k, 32'(ptr_a[k]), 32'h0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(4'b1111, 1'b0);
        chk("post_rst_sel", 0, 32'(sel_a[0]), 32'h1);
        chk("post_rst_ptr", 0, 32'(ptr_a[0]), 32'd1);

        // Random traffic with sticky requests and occasional inhibit.
        r = 4'b0000;
        repeat (10000) begin
            if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
            inh = ($urandom_range(7) == 0);
            cycle(r, inh);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
